sw_array_ctrl: RTL and testbench
================================

# sw_array_ctrl

Sequencer for the N-PE Smith-Waterman systolic array. It latches a read and a reference length on `start` and preloads the read into the PEs. It then clears the array state, streams reference bases in from an upstream valid/ready source, and drains the wavefront. While the array runs, it tracks the best cell score reported by any PE. It sits between the alignment job front-end and the `pe` array, and it replaces the hand-driven `read_load_en` / `clear_en` / `compute_en` / `ref_in` sequencing used in array-level benches.

## Interface
- `N`, 5: number of PEs, equal to the read length.
- `SCORE_W`, 8: signed PE score width.
- `MAX_REF`, 64: maximum reference window length.
- `LEN_W`, $clog2(MAX_REF+1): width of `ref_len`.
- `CYC_W`, $clog2(MAX_REF+N+2): width of the compute-cycle counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  job request; accepted only in IDLE.
- `read_seq`  in  2*N  read bases; PE i uses bits [2i+1:2i]. Encoding A=0, C=1, G=2, T=3.
- `ref_len`  in  LEN_W  reference length M, sampled on start.
- `abort`  in  1  cancels the job; returns to IDLE.
- `ref_base`  in  2  upstream reference base.
- `ref_valid`  in  1  upstream base available.
- `ref_ready`  out  1  controller accepts a base this cycle.
- `read_load_en`  out  1  to array.
- `read_base_out`  out  2*N  to the array's per-PE `read_base_in`.
- `clear_en`  out  1  to array.
- `compute_en`  out  1  to array; advances the ref pipe and the PEs.
- `ref_in`  out  2  base injected at PE0.
- `ref_valid_in`  out  1  marks a real base at PE0.
- `pe_score`  in  N*SCORE_W  per-PE signed scores, from the array.
- `pe_out_valid`  in  N  per-PE out_valid, from the array.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a job.
- `best_score`  out  SCORE_W  signed maximum score; held until the next CLEAR.
- `best_pe`  out  $clog2(N)  PE index of the maximum.
- `best_cyc`  out  CYC_W  compute-cycle index at which the maximum was sampled.

## Operation
The FSM states are IDLE, LOAD, CLEAR, RUN, DRAIN, DONE.

- **IDLE**
  - When `start` is high, latch `read_seq` and `ref_len` and go to LOAD.
  - `start` is ignored in all other states.
- **LOAD** (1 cycle)
  - Drive `read_load_en`=1 with `read_base_out` set to the latched read.
  - Go to CLEAR.
  - `read_base_out` holds the latched read in every state; it is 0 only after reset.
- **CLEAR** (1 cycle)
  - Drive `clear_en`=1.
  - Set `best_score`=0, `best_pe`=0, `best_cyc`=0, and zero the injected-base counter `inj` and the compute counter `cyc`.
  - Go to RUN, or to DRAIN if M==0.
- **RUN**
  - `ref_ready` = (`inj` < M).
  - A handshake fires when `ref_valid` && `ref_ready`. On a fire: `compute_en`=1, `ref_valid_in`=1, `ref_in`=`ref_base`, and `inj` increments.
  - Without a fire: `compute_en`=0, `ref_valid_in`=0, `ref_in`=0, and the array freezes. A stall may last any number of cycles.
  - Go to DRAIN on the fire that brings `inj` to M.
- **DRAIN**
  - `compute_en`=1, `ref_valid_in`=0, `ref_in`=0, `ref_ready`=0.
  - Lasts exactly N cycles: N-1 cycles to flush the wavefront plus 1 cycle for the PE output register.
  - Then go to DONE.
- **DONE** (1 cycle)
  - `done`=1, then go to IDLE.
  - `best_*` values stay valid until the next CLEAR.
- **Counting**
  - `cyc` increments on every cycle with `compute_en`=1.
- **Best-score tracking**
  - Active in RUN, DRAIN and DONE, on every cycle regardless of `compute_en`.
  - For each i with `pe_out_valid[i]`, compare `pe_score[i]` signed against the current best.
  - An update requires strictly greater. Within one cycle, the lowest i wins ties. Across cycles, the earliest cycle wins ties.
  - On an update, `best_cyc` takes the value of `cyc` in that cycle.
- **abort**
  - In any non-IDLE state, `abort` forces the next state to IDLE.
  - In the abort cycle itself: `compute_en`, `ref_ready` and `ref_valid_in` are 0. No `done` is produced.
  - `best_*` values are left undefined-but-stable.
  - `abort` takes precedence over every other transition.

## Timing
- **Reset**
  - All outputs are 0, the FSM is in IDLE, and all counters are 0.
  - Reset asserted mid-job has the same effect as abort and also zeroes `best_*`.
- **Start to control pulses**
  - `start` sampled at edge k gives `read_load_en` during cycle k+1 and `clear_en` during cycle k+2.
  - The first possible `compute_en` is cycle k+3.
- **Job length with no stalls:** k+3 through k+2+M+N is compute (M+N cycles), and `done` falls in cycle k+3+M+N.
- **Combinational paths**
  - `ref_ready`, `compute_en`, `ref_in` and `ref_valid_in` are combinational from state, counters and `ref_valid`.
  - No other output depends combinationally on an input.
- **Counter width:** `cyc` never exceeds M+N, so it does not wrap.
- **ref_len range:** `ref_len` > MAX_REF is clamped to MAX_REF at latch time.

## Structure
- **Package `sw_pkg`:**
  - base encoding localparams (A, C, G, T)
  - `ctrl_state_t` enum
  - the SCORE_W default
  - a `base_t` typedef (logic [1:0])
- **Sub-module `sw_best_tracker`:** the N-way signed max with index and tie rules. It is purely combinational plus the `best_*` registers, with a clear input driven in CLEAR.

## Test plan
- **Nominal, no stalls.** Stimulus: read GAGCT; M=5 with bases AGCGT and `ref_valid` held high. Required response:
  - exactly 1 `read_load_en` cycle, then 1 `clear_en` cycle;
  - `compute_en` high for 10 consecutive cycles, with `ref_valid_in` high for the first 5 carrying 0, 2, 1, 2, 3;
  - `done` the cycle after.
- **Stalls.** Stimulus: as nominal, with `ref_valid` low on the 2nd and 4th offered cycles. Required response: `compute_en` low on exactly those cycles, the base order is unchanged, and total compute cycles = 10.
- **Best tracking.** Stimulus: a stub array drives `pe_out_valid`=11111. Scores are 3 at PE2, cyc 4; 7 at PE1 and PE3, both at cyc 6; and 7 at PE0, cyc 8. Required response: `best_score`=7, `best_pe`=1, `best_cyc`=6. A negative score -5 with `pe_out_valid` never raises the best above the cleared value of 0.
- **Abort.** Stimulus: abort in the 3rd RUN cycle. Required response: next cycle IDLE with `busy`=0, `ref_ready`=0 and no `done`. A new `start` then runs a complete nominal job.
- **Edge lengths.** Stimulus: M=0. Required response: CLEAR is followed by N DRAIN cycles with `ref_valid_in`=0, then `done` with `best_score`=0.
- **Edge lengths.** Stimulus: M=MAX_REF. Required response: `best_cyc` reaches up to MAX_REF+N-1 without wrapping.
- **Reset mid-DRAIN.** Stimulus: `rst_n` low for 1 cycle during DRAIN. Required response: all outputs are 0 on the following cycle.
- **Start ignored while busy.** Stimulus: `start` held high through the whole job. Required response: a new job starts only from IDLE, i.e. LOAD follows DONE→IDLE by one cycle.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman array sequencer.
package sw_pkg;

  typedef logic [1:0] base_t;

  localparam base_t BASE_A = 2'd0;
  localparam base_t BASE_C = 2'd1;
  localparam base_t BASE_G = 2'd2;
  localparam base_t BASE_T = 2'd3;

  localparam int SCORE_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } ctrl_state_t;

endpackage

// File: rtl/sw_best_tracker.sv
// Running signed maximum over the PE score lanes, with the winning PE index
// and the compute-cycle index at which it was seen.
module sw_best_tracker #(
  parameter int N       = 5,
  parameter int SCORE_W = 8,
  parameter int CYC_W   = 7,
  parameter int IDX_W   = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      en,
  input  logic [N*SCORE_W-1:0]      pe_score,
  input  logic [N-1:0]              pe_out_valid,
  input  logic [CYC_W-1:0]          cyc,
  output logic signed [SCORE_W-1:0] best_score,
  output logic [IDX_W-1:0]          best_pe,
  output logic [CYC_W-1:0]          best_cyc
);

  logic signed [SCORE_W-1:0] cand_score;
  logic signed [SCORE_W-1:0] lane;
  logic [IDX_W-1:0]          cand_pe;
  logic                      hit;

  // Scan from PE0 upward against the running candidate; strict compare keeps
  // the lowest index on ties and never displaces an equal earlier best.
  always_comb begin
    cand_score = best_score;
    cand_pe    = best_pe;
    hit        = 1'b0;
    lane       = '0;
    for (int i = 0; i < N; i++) begin
      lane = $signed(pe_score[i*SCORE_W +: SCORE_W]);
      if (pe_out_valid[i] && (lane > cand_score)) begin
        cand_score = lane;
        cand_pe    = IDX_W'(i);
        hit        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_score <= '0;
      best_pe    <= '0;
      best_cyc   <= '0;
    end else if (clear) begin
      best_score <= '0;
      best_pe    <= '0;
      best_cyc   <= '0;
    end else if (en && hit) begin
      best_score <= cand_score;
      best_pe    <= cand_pe;
      best_cyc   <= cyc;
    end
  end

endmodule

// File: rtl/sw_array_ctrl.sv
// Job sequencer for the N-PE Smith-Waterman systolic array.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | read_load_en, read preloaded into PEs
//   CLEAR | clear_en, array and best/counters zeroed
//   RUN   | stream M reference bases, compute on each handshake
//   DRAIN | N free-running compute cycles to flush the wavefront
//   DONE  | one-cycle done pulse
module sw_array_ctrl
  import sw_pkg::*;
#(
  parameter int N       = 5,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int MAX_REF = 64,
  parameter int LEN_W   = $clog2(MAX_REF + 1),
  parameter int CYC_W   = $clog2(MAX_REF + N + 2),
  parameter int IDX_W   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*N-1:0]       read_seq,
  input  logic [LEN_W-1:0]     ref_len,
  input  logic                 abort,
  input  base_t                ref_base,
  input  logic                 ref_valid,
  output logic                 ref_ready,
  output logic                 read_load_en,
  output logic [2*N-1:0]       read_base_out,
  output logic                 clear_en,
  output logic                 compute_en,
  output base_t                ref_in,
  output logic                 ref_valid_in,
  input  logic [N*SCORE_W-1:0] pe_score,
  input  logic [N-1:0]         pe_out_valid,
  output logic                 busy,
  output logic                 done,
  output logic [SCORE_W-1:0]   best_score,
  output logic [IDX_W-1:0]     best_pe,
  output logic [CYC_W-1:0]     best_cyc
);

  localparam int DRAIN_W = $clog2(N + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_REF);

  ctrl_state_t        state;
  ctrl_state_t        nxt;
  logic [2*N-1:0]     read_q;
  logic [LEN_W-1:0]   m_len;
  logic [LEN_W-1:0]   inj;
  logic [CYC_W-1:0]   cyc;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               fire;
  logic               last_fire;

  assign read_base_out = read_q;

  // Handshake and array strobes; abort kills them in its own cycle.
  always_comb begin
    ref_ready    = (state == S_RUN) && (inj < m_len) && !abort;
    fire         = ref_ready && ref_valid;
    ref_valid_in = fire;
    ref_in       = fire ? ref_base : BASE_A;
    compute_en   = fire || ((state == S_DRAIN) && !abort);
  end

  assign last_fire = fire && ((inj + LEN_W'(1)) == m_len);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = S_LOAD;
      S_LOAD:  nxt = S_CLEAR;
      S_CLEAR: nxt = (m_len == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (last_fire) nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      read_q       <= '0;
      m_len        <= '0;
      inj          <= '0;
      cyc          <= '0;
      drain_cnt    <= '0;
      read_load_en <= 1'b0;
      clear_en     <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt;
      read_load_en <= (nxt == S_LOAD);
      clear_en     <= (nxt == S_CLEAR);
      done         <= (nxt == S_DONE);
      busy         <= (nxt != S_IDLE);

      if ((state == S_IDLE) && start) begin
        read_q <= read_seq;
        m_len  <= (ref_len > MAX_LEN) ? MAX_LEN : ref_len;
      end

      if (state == S_CLEAR) begin
        inj <= '0;
        cyc <= '0;
      end else begin
        if (fire)       inj <= inj + LEN_W'(1);
        if (compute_en) cyc <= cyc + CYC_W'(1);
      end

      // Down-counter loaded with N-1 on entry gives exactly N DRAIN cycles.
      if ((nxt == S_DRAIN) && (state != S_DRAIN))
        drain_cnt <= DRAIN_W'(N - 1);
      else if ((state == S_DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - DRAIN_W'(1);
    end
  end

  sw_best_tracker #(
    .N       (N),
    .SCORE_W (SCORE_W),
    .CYC_W   (CYC_W),
    .IDX_W   (IDX_W)
  ) u_best (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (state == S_CLEAR),
    .en           ((state == S_RUN) || (state == S_DRAIN) || (state == S_DONE)),
    .pe_score     (pe_score),
    .pe_out_valid (pe_out_valid),
    .cyc          (cyc),
    .best_score   (best_score),
    .best_pe      (best_pe),
    .best_cyc     (best_cyc)
  );

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl: expected reference bases are queued when a
// job is issued and popped as the controller injects them into PE0.
module tb_sw_array_ctrl;

  localparam int N       = 5;
  localparam int SCORE_W = 8;
  localparam int MAX_REF = 64;
  localparam int LEN_W   = 7;
  localparam int CYC_W   = 7;
  localparam int IDX_W   = 3;
  localparam logic [9:0] READ_GAGCT = {2'd3, 2'd1, 2'd2, 2'd0, 2'd2};

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [2*N-1:0]       read_seq;
  logic [LEN_W-1:0]     ref_len;
  logic                 abort;
  logic [1:0]           ref_base;
  logic                 ref_valid;
  logic                 ref_ready;
  logic                 read_load_en;
  logic [2*N-1:0]       read_base_out;
  logic                 clear_en;
  logic                 compute_en;
  logic [1:0]           ref_in;
  logic                 ref_valid_in;
  logic [N*SCORE_W-1:0] pe_score;
  logic [N-1:0]         pe_out_valid;
  logic                 busy;
  logic                 done;
  logic [SCORE_W-1:0]   best_score;
  logic [IDX_W-1:0]     best_pe;
  logic [CYC_W-1:0]     best_cyc;

  sw_array_ctrl #(.N(N), .SCORE_W(SCORE_W), .MAX_REF(MAX_REF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .read_seq(read_seq),
    .ref_len(ref_len), .abort(abort), .ref_base(ref_base),
    .ref_valid(ref_valid), .ref_ready(ref_ready),
    .read_load_en(read_load_en), .read_base_out(read_base_out),
    .clear_en(clear_en), .compute_en(compute_en), .ref_in(ref_in),
    .ref_valid_in(ref_valid_in), .pe_score(pe_score),
    .pe_out_valid(pe_out_valid), .busy(busy), .done(done),
    .best_score(best_score), .best_pe(best_pe), .best_cyc(best_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [1:0]   base_mem [0:127];
  logic [127:0] stall_mask;
  int           def_score;
  int           n_ent;
  int           ent_cyc [0:7];
  int           ent_pe  [0:7];
  int           ent_sc  [0:7];
  bit           ent_vld [0:7];
  logic [1:0]   exp_q [$];

  int n_load, load_t, n_clear, clear_t, n_comp, first_comp, last_comp;
  int n_vin, n_done, done_t, n_busy, bad_refin;
  logic [9:0]   load_rd;
  logic [255:0] comp_vec, load_vec, busy_vec;
  logic [7:0]   d_score;
  logic [2:0]   d_pe;
  logic [6:0]   d_cyc;
  bit           finished;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({busy, done, read_load_en, clear_en, compute_en,
                             ref_ready, ref_valid_in, ref_in}), 0);
    chk({tag, "_read_best"}, 32'({read_base_out, best_score}), 0);
    chk({tag, "_pe_cyc"}, 32'({best_pe, best_cyc}), 0);
  endtask

  task automatic cfg_clear();
    stall_mask = '0;
    def_score  = 0;
    n_ent      = 0;
    for (int i = 0; i < 128; i++) base_mem[i] = 2'($urandom);
    base_mem[0] = 2'd0; base_mem[1] = 2'd2; base_mem[2] = 2'd1;
    base_mem[3] = 2'd2; base_mem[4] = 2'd3;
  endtask

  task automatic add_ent(input int c, input int p, input int s, input bit v);
    ent_cyc[n_ent] = c; ent_pe[n_ent] = p; ent_sc[n_ent] = s; ent_vld[n_ent] = v;
    n_ent++;
  endtask

  task automatic run_job(input logic [9:0] rd, input int m, input int abort_t,
                         input int rst_t, input bit hold_start);
    int t, offer, bidx;
    logic [N*SCORE_W-1:0] ps;
    logic [N-1:0] pv;
    n_load = 0; load_t = -1; n_clear = 0; clear_t = -1; n_comp = 0;
    first_comp = -1; last_comp = -1; n_vin = 0; n_done = 0; done_t = -1;
    n_busy = 0; bad_refin = 0; load_rd = '0; comp_vec = '0; load_vec = '0;
    busy_vec = '0; finished = 0; d_score = '0; d_pe = '0; d_cyc = '0;
    exp_q.delete();
    for (int i = 0; i < m; i++) exp_q.push_back(base_mem[i]);
    @(posedge clk); #1;
    start = 1'b1; read_seq = rd; ref_len = LEN_W'(m); abort = 1'b0;
    t = 0; offer = 0; bidx = 0;
    while (!finished && t < 200) begin
      @(posedge clk); #1;
      t++;
      if (!hold_start) start = 1'b0;
      abort = (t == abort_t);
      rst_n = (t != rst_t);
      for (int i = 0; i < N; i++) ps[i*SCORE_W +: SCORE_W] = 8'(def_score);
      pv = '1;
      for (int e = 0; e < n_ent; e++)
        if (ent_cyc[e] == t - 3) begin
          ps[ent_pe[e]*SCORE_W +: SCORE_W] = 8'(ent_sc[e]);
          if (!ent_vld[e]) pv[ent_pe[e]] = 1'b0;
        end
      pe_score = ps; pe_out_valid = pv;
      #1;
      if (ref_ready) begin
        ref_valid = !stall_mask[offer];
        offer++;
      end else ref_valid = 1'b1;
      ref_base = (ref_valid && ref_ready) ? base_mem[bidx] : 2'($urandom);
      @(negedge clk);
      if (read_load_en) begin
        n_load++;
        if (load_t < 0) begin load_t = t; load_rd = read_base_out; end
      end
      load_vec[t] = read_load_en; comp_vec[t] = compute_en; busy_vec[t] = busy;
      if (clear_en) begin n_clear++; if (clear_t < 0) clear_t = t; end
      if (compute_en) begin
        n_comp++;
        if (first_comp < 0) first_comp = t;
        last_comp = t;
      end
      if (busy) n_busy++;
      if (ref_valid_in) begin
        n_vin++;
        if (exp_q.size() > 0) chk("ref_in_order", 32'(ref_in), 32'(exp_q.pop_front()));
        else chk("ref_in_extra", 32'(ref_valid_in), 0);
      end else if (ref_in != 2'd0) bad_refin++;
      if (ref_valid && ref_ready) bidx++;
      if (done) begin
        n_done++;
        if (done_t < 0) begin
          done_t = t; d_score = best_score; d_pe = best_pe; d_cyc = best_cyc;
        end
      end
      if (abort_t > 0 && t == abort_t) begin
        chk("abort_cyc_compute_en", 32'(compute_en), 0);
        chk("abort_cyc_ref_ready", 32'(ref_ready), 0);
        chk("abort_cyc_ref_valid_in", 32'(ref_valid_in), 0);
      end
      if (abort_t > 0 && t == abort_t + 1) begin
        chk("abort_next_busy", 32'(busy), 0);
        chk("abort_next_ref_ready", 32'(ref_ready), 0);
        chk("abort_next_done", 32'(done), 0);
        finished = 1;
      end
      if (rst_t > 0 && t == rst_t + 1) begin
        chk_all_zero("reset_mid_drain");
        finished = 1;
      end
      if (done && !hold_start) finished = 1;
      if (hold_start && done_t > 0 && t == done_t + 2) finished = 1;
    end
    ref_valid = 1'b0;
    pe_score = '0; pe_out_valid = '0;
    chk("job_finished", 32'(finished), 1);
  endtask

  task automatic chk_nominal(input string tag, input int stalls);
    chk({tag, "_n_load"}, n_load, 1);
    chk({tag, "_load_t"}, load_t, 1);
    chk({tag, "_load_read"}, 32'(load_rd), 32'(READ_GAGCT));
    chk({tag, "_n_clear"}, n_clear, 1);
    chk({tag, "_clear_t"}, clear_t, 2);
    chk({tag, "_first_comp"}, first_comp, 3);
    chk({tag, "_n_comp"}, n_comp, 10);
    chk({tag, "_last_comp"}, last_comp, 12 + stalls);
    chk({tag, "_n_vin"}, n_vin, 5);
    chk({tag, "_done_t"}, done_t, 13 + stalls);
    chk({tag, "_n_done"}, n_done, 1);
    chk({tag, "_n_busy"}, n_busy, 13 + stalls);
    chk({tag, "_bad_refin"}, bad_refin, 0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; read_seq = '0; ref_len = '0; abort = 1'b0;
    ref_base = '0; ref_valid = 1'b0; pe_score = '0; pe_out_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // nominal, no stalls
    cfg_clear();
    run_job(READ_GAGCT, 5, -1, -1, 0);
    chk_nominal("nominal", 0);
    chk("nominal_best_score", 32'(d_score), 0);

    // stalls on the 2nd and 4th offered cycles
    cfg_clear();
    stall_mask[1] = 1'b1; stall_mask[3] = 1'b1;
    run_job(READ_GAGCT, 5, -1, -1, 0);
    chk_nominal("stall", 2);
    chk("stall_comp_t4", 32'(comp_vec[4]), 0);
    chk("stall_comp_t5", 32'(comp_vec[5]), 1);
    chk("stall_comp_t6", 32'(comp_vec[6]), 0);

    // best tracking with ties inside and across cycles
    cfg_clear();
    add_ent(4, 2, 3, 1); add_ent(5, 4, -5, 1);
    add_ent(6, 1, 7, 1); add_ent(6, 3, 7, 1); add_ent(8, 0, 7, 1);
    run_job(READ_GAGCT, 5, -1, -1, 0);
    chk("best_score", 32'(d_score), 7);
    chk("best_pe", 32'(d_pe), 1);
    chk("best_cyc", 32'(d_cyc), 6);

    // negative scores never beat the cleared best
    cfg_clear();
    def_score = -5;
    run_job(READ_GAGCT, 5, -1, -1, 0);
    chk("neg_best_score", 32'(d_score), 0);
    chk("neg_best_pe", 32'(d_pe), 0);
    chk("neg_best_cyc", 32'(d_cyc), 0);

    // abort in the 3rd RUN cycle, then a clean job
    cfg_clear();
    run_job(READ_GAGCT, 5, 5, -1, 0);
    chk("abort_n_done", n_done, 0);
    cfg_clear();
    run_job(READ_GAGCT, 5, -1, -1, 0);
    chk_nominal("post_abort", 0);

    // M = 0
    cfg_clear();
    run_job(READ_GAGCT, 0, -1, -1, 0);
    chk("m0_n_clear", n_clear, 1);
    chk("m0_first_comp", first_comp, 3);
    chk("m0_n_comp", n_comp, N);
    chk("m0_n_vin", n_vin, 0);
    chk("m0_done_t", done_t, 3 + N);
    chk("m0_best_score", 32'(d_score), 0);

    // M = MAX_REF, best found on the very last compute cycle
    cfg_clear();
    add_ent(10, 4, 50, 0); add_ent(30, 2, 8, 1); add_ent(MAX_REF + N - 1, 4, 9, 1);
    run_job(READ_GAGCT, MAX_REF, -1, -1, 0);
    chk("mmax_n_comp", n_comp, MAX_REF + N);
    chk("mmax_done_t", done_t, 3 + MAX_REF + N);
    chk("mmax_sb_empty", exp_q.size(), 0);
    chk("mmax_best_score", 32'(d_score), 9);
    chk("mmax_best_pe", 32'(d_pe), 4);
    chk("mmax_best_cyc", 32'(d_cyc), MAX_REF + N - 1);

    // reset pulse in DRAIN with a nonzero best pending
    cfg_clear();
    add_ent(2, 0, 5, 1);
    run_job(READ_GAGCT, 5, -1, 9, 0);
    chk("rst_n_done", n_done, 0);

    // start held through the job
    cfg_clear();
    run_job(READ_GAGCT, 5, -1, -1, 1);
    chk("hold_done_t", done_t, 13);
    chk("hold_n_load", n_load, 2);
    chk("hold_n_clear", n_clear, 1);
    chk("hold_idle_busy", 32'(busy_vec[14]), 0);
    chk("hold_idle_load", 32'(load_vec[14]), 0);
    chk("hold_reload", 32'(load_vec[15]), 1);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("hold_abort_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
